// File: rtl/fft_pkg.sv
// Shared constants, loader state type and index helper for the 16-point FFT front end.
package fft_pkg;

  localparam int N      = 16;
  localparam int LOG2N  = 4;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } loader_state_e;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_input_loader.sv
// Collects a 16-sample complex frame into a capture bank in bit-reversed slot order and
// presents the whole frame on a separate output bank for one out_valid pulse per frame.
module fft16_input_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 16   // only 16 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_im,
  output logic              in_ready,
  output logic [DATA_W-1:0] X0_Real,  X1_Real,  X2_Real,  X3_Real,
  output logic [DATA_W-1:0] X4_Real,  X5_Real,  X6_Real,  X7_Real,
  output logic [DATA_W-1:0] X8_Real,  X9_Real,  X10_Real, X11_Real,
  output logic [DATA_W-1:0] X12_Real, X13_Real, X14_Real, X15_Real,
  output logic [DATA_W-1:0] X0_Im,    X1_Im,    X2_Im,    X3_Im,
  output logic [DATA_W-1:0] X4_Im,    X5_Im,    X6_Im,    X7_Im,
  output logic [DATA_W-1:0] X8_Im,    X9_Im,    X10_Im,   X11_Im,
  output logic [DATA_W-1:0] X12_Im,   X13_Im,   X14_Im,   X15_Im,
  output logic              out_valid,
  output logic              frame_err,
  output loader_state_e     state
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready is held high from the first edge after reset release, so there is no backpressure.

  logic [DATA_W-1:0] cap_re [N];
  logic [DATA_W-1:0] cap_im [N];
  logic [DATA_W-1:0] out_re [N];
  logic [DATA_W-1:0] out_im [N];
  logic [LOG2N-1:0]  count;
  logic              copy_pend;
  logic              accept;
  logic              wr_en;
  logic [LOG2N-1:0]  wr_slot;

  assign accept = in_valid & in_ready;

  always_comb begin
    wr_en   = 1'b0;
    wr_slot = '0;
    if (accept) begin
      if (in_sop) begin
        wr_en = 1'b1;
      end else if (state == FILL) begin
        wr_en   = 1'b1;
        wr_slot = bitrev4(count);
      end
    end
  end

  // Capture bank carries no reset: its contents are meaningless until a frame completes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      cap_re[wr_slot] <= in_real;
      cap_im[wr_slot] <= in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      copy_pend <= 1'b0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        out_re[i] <= '0;
        out_im[i] <= '0;
      end
    end else begin
      in_ready  <= 1'b1;
      out_valid <= copy_pend;
      frame_err <= 1'b0;
      copy_pend <= 1'b0;
      // The copy reads the bank one edge after the last write, so it sees index 15 too;
      // a back-to-back sop landing on this edge writes slot 0 only after the copy samples it.
      if (copy_pend) begin
        out_re <= cap_re;
        out_im <= cap_im;
      end
      if (accept) begin
        if (in_sop) begin
          frame_err <= (state == FILL);
          state     <= FILL;
          count     <= 4'd1;
        end else if (state == FILL) begin
          count <= count + 4'd1;
          if (count == 4'd15) begin
            state     <= IDLE;
            copy_pend <= 1'b1;
          end
        end
      end
    end
  end

  assign X0_Real  = out_re[0];   assign X0_Im  = out_im[0];
  assign X1_Real  = out_re[1];   assign X1_Im  = out_im[1];
  assign X2_Real  = out_re[2];   assign X2_Im  = out_im[2];
  assign X3_Real  = out_re[3];   assign X3_Im  = out_im[3];
  assign X4_Real  = out_re[4];   assign X4_Im  = out_im[4];
  assign X5_Real  = out_re[5];   assign X5_Im  = out_im[5];
  assign X6_Real  = out_re[6];   assign X6_Im  = out_im[6];
  assign X7_Real  = out_re[7];   assign X7_Im  = out_im[7];
  assign X8_Real  = out_re[8];   assign X8_Im  = out_im[8];
  assign X9_Real  = out_re[9];   assign X9_Im  = out_im[9];
  assign X10_Real = out_re[10];  assign X10_Im = out_im[10];
  assign X11_Real = out_re[11];  assign X11_Im = out_im[11];
  assign X12_Real = out_re[12];  assign X12_Im = out_im[12];
  assign X13_Real = out_re[13];  assign X13_Im = out_im[13];
  assign X14_Real = out_re[14];  assign X14_Im = out_im[14];
  assign X15_Real = out_re[15];  assign X15_Im = out_im[15];

endmodule
